// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: req/ready handshake, pipeline stall/bubble, load-data capture.
// Optional REQ-state abort timer enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadin,
    input  logic              MemWritein,
    input  logic [ADDR_W-1:0] aluresult,
    input  logic [ADDR_W-1:0] wdata,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              stall,
    output logic              bubble,
    output logic [ADDR_W-1:0] rdata,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_nxt;
    logic   access;
    logic   timeout_hit;

    assign access = MemReadin | MemWritein;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt;

    // Completion on the final cycle wins over the abort.
    assign timeout_hit = (state == REQ) && !mem_ready && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state == IDLE && access)
            cnt <= '0;
        else if (state == REQ && !mem_ready)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timeout_err <= 1'b0;
        else if (timeout_hit)
            timeout_err <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ready || timeout_hit)
                    state_nxt = DONE;
            end
            // EX/MEM still holds the finished instruction here, so access is ignored.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bubble = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWritein;
                        mem_addr  <= aluresult;
                        mem_wdata <= wdata;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            rdata <= mem_rdata;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        rdata   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory port fed by the EX/MEM pipeline register. It detects a load or store in EX/MEM and runs a req/ready handshake with a variable-latency data memory. While the access is pending it stalls the front of the pipeline and injects a bubble into MEM/WB. It captures load data for the writeback stage.

## Interface
Parameters:
- ADDR_W, 32, address and data width
- TIMEOUT, 64, maximum REQ-state cycles before abort; used only when MEM_TIMEOUT_EN is defined

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- MemReadin  input  1  MemRead from the EX/MEM register output
- MemWritein  input  1  MemWrite from the EX/MEM register output
- aluresult  input  ADDR_W  effective address from the EX/MEM register output
- wdata  input  ADDR_W  store data
- mem_ready  input  1  memory completion strobe, one cycle
- mem_rdata  input  ADDR_W  load data, valid when mem_ready=1
- mem_req  output  1  registered request to memory
- mem_we  output  1  registered write enable: 1 = store, 0 = load
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  ADDR_W  registered store data
- stall  output  1  holds PC, IF/ID, ID/EX and EX/MEM (combinational)
- bubble  output  1  zeroes MEM/WB control bits this cycle; equals stall
- rdata  output  ADDR_W  captured load data for MEM/WB
- timeout_err  output  1  sticky abort flag

## Operation
- access = MemReadin | MemWritein.
- If both inputs are 1, the access is treated as a store.
- States:
  - IDLE: if access, stall=1. Next edge: latch aluresult, wdata and MemWritein into mem_addr, mem_wdata and mem_we; set mem_req=1; go to REQ. Otherwise stay in IDLE with stall=0.
  - REQ: stall=1 and mem_req held at 1. On an edge with mem_ready=1: clear mem_req; if the access is a load (mem_we=0), capture mem_rdata into rdata; go to DONE.
  - DONE: stall=0 for exactly one cycle so the pipeline advances. access is ignored in this state, because EX/MEM still holds the completed instruction. Next state is IDLE unconditionally.
- mem_ready is ignored in IDLE and DONE.
- mem_addr, mem_wdata and mem_we stay stable for the whole time mem_req=1.
- rdata holds its value until the next load completes. A store leaves rdata unchanged.

## Timing
- Reset values: state=IDLE; mem_req, mem_we, stall, bubble and timeout_err = 0; mem_addr, mem_wdata and rdata = 0.
- Reset asserted mid-access drops mem_req asynchronously. The pending access is abandoned and is not retried.
- Minimum occupancy per memory instruction is 3 cycles (IDLE-detect, REQ, DONE). This occurs when mem_ready arrives in the first REQ cycle.
- Each extra memory wait cycle adds exactly one stall cycle.
- Two back-to-back memory instructions: the second is detected in the IDLE cycle that follows DONE. There is no gap beyond the 3-cycle minimum.
- Non-memory instructions see stall=0 and incur zero added latency.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An internal counter, sized as $clog2(TIMEOUT)+1 bits, clears on REQ entry and increments each cycle in REQ while mem_ready=0.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0: clear mem_req, set rdata=0 and timeout_err=1, and go to DONE.
  - If mem_ready=1 on that same cycle, the access completes normally and no error is raised.
  - timeout_err stays 1 until reset.
- MEM_TIMEOUT_EN undefined:
  - REQ waits indefinitely for mem_ready.
  - No counter is built.
  - timeout_err is tied to 0.

## Test plan
- Reset, then a load with MemReadin=1, aluresult=0x100, and mem_ready on the first REQ cycle with mem_rdata=0xDEADBEEF -> mem_req high for 1 cycle with mem_addr=0x100 and mem_we=0; stall high for 2 cycles; rdata=0xDEADBEEF in DONE.
- Store with MemWritein=1, wdata=0x55, and mem_ready delayed 4 cycles -> mem_we=1 and mem_wdata=0x55 stable throughout; stall high for 6 cycles; rdata unchanged.
- Back-to-back load then store -> second mem_req rises 2 cycles after the first request completes; no duplicate request for the first instruction.
- Reset pulsed while in REQ -> mem_req, stall and bubble drop without waiting for a clock edge; a later mem_ready is ignored; the next access proceeds normally.
- MEM_TIMEOUT_EN with TIMEOUT=8 and mem_ready never asserted -> mem_req drops after 8 REQ cycles; timeout_err=1 and rdata=0; timeout_err stays 1 through later successful accesses until reset.
- MemReadin=MemWritein=1 -> mem_we=1 (store priority), with a single request.
